// File: rtl/instruction_loader_if.sv
// Instruction loader bus: UART byte stream in, instruction memory write port out.
// The loader owns the write side (master); the surrounding system drives bytes
// and the start command and consumes the write strobes and status (slave).
interface instruction_loader_if #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 13
);
  localparam int ADDR_W = $clog2(MAX_INSTRUCTION);

  logic              i_start;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [SIZE-1:0]   o_wr_data;
  logic              o_loading;
  logic              o_done;
  logic              o_full;
  logic [ADDR_W:0]   o_word_count;

  modport master (
    input  i_start,
    input  i_rx_data,
    input  i_rx_valid,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    output o_loading,
    output o_done,
    output o_full,
    output o_word_count
  );

  modport slave (
    output i_start,
    output i_rx_data,
    output i_rx_valid,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_loading,
    input  o_done,
    input  o_full,
    input  o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Writer side of the fetch-stage instruction memory. After a start command it
// assembles big-endian 32-bit words from a byte stream and writes them to
// consecutive word addresses until an all-ones end marker or the last memory
// slot. The pipeline is held stalled (o_loading) for the whole load.
// The assembly logic is fixed at four bytes per word, so SIZE must be 32.
module instruction_loader #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 13
) (
  input logic                 clk,
  input logic                 rst,
  instruction_loader_if.master bus
);

  localparam int ADDR_W = $clog2(MAX_INSTRUCTION);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAX_INSTRUCTION - 1);
  localparam logic [SIZE-1:0]   END_MARKER = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Only the three most recent bytes need storing: the fourth byte of a word
  // is combined with them directly to form the candidate word.
  logic [23:0]       shift, shift_next;
  logic [1:0]        byte_cnt, byte_cnt_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [ADDR_W:0]   count, count_next;
  logic              full, full_next;
  logic              wr_en, wr_en_next;
  logic [ADDR_W-1:0] wr_addr, wr_addr_next;
  logic [SIZE-1:0]   wr_data, wr_data_next;
  logic [SIZE-1:0]   candidate;

  assign candidate = {shift, bus.i_rx_data};

  // State register; reset returns to IDLE and abandons any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: assembly shift, counters and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      byte_cnt <= '0;
      addr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      shift    <= shift_next;
      byte_cnt <= byte_cnt_next;
      addr     <= addr_next;
      count    <= count_next;
      full     <= full_next;
      wr_en    <= wr_en_next;
      wr_addr  <= wr_addr_next;
      wr_data  <= wr_data_next;
    end
  end

  // Next-state and datapath decisions; the write strobe defaults low so it
  // only ever lasts one cycle, while address/data hold their last values.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    byte_cnt_next = byte_cnt;
    addr_next     = addr;
    count_next    = count;
    full_next     = full;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr;
    wr_data_next  = wr_data;

    case (state)
      IDLE, DONE: begin
        // Bytes are ignored here, even in the same cycle as the start command.
        if (bus.i_start) begin
          state_next    = RECV;
          shift_next    = '0;
          byte_cnt_next = '0;
          addr_next     = '0;
          count_next    = '0;
          full_next     = 1'b0;
        end
      end

      RECV: begin
        // A start command during a load is ignored.
        if (bus.i_rx_valid) begin
          shift_next = candidate[23:0];
          if (byte_cnt == 2'd3) begin
            byte_cnt_next = '0;
            if (candidate == END_MARKER) begin
              state_next = DONE;
            end else begin
              wr_en_next   = 1'b1;
              wr_addr_next = addr;
              wr_data_next = candidate;
              count_next   = count + 1'b1;
              if (addr == LAST_ADDR) begin
                // Memory is full: stop here so the address never runs past the end.
                state_next = DONE;
                full_next  = 1'b1;
              end else begin
                addr_next = addr + 1'b1;
              end
            end
          end else begin
            byte_cnt_next = byte_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.o_wr_en      = wr_en;
  assign bus.o_wr_addr    = wr_addr;
  assign bus.o_wr_data    = wr_data;
  assign bus.o_loading    = (state == RECV);
  assign bus.o_done       = (state == DONE);
  assign bus.o_full       = full;
  assign bus.o_word_count = count;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: a table of hand-computed vectors
// for a normal load and a restart, hand-written corner-case sequences, and a
// randomized run checked cycle by cycle against a byte-queue reference model.
module tb_instruction_loader;

  localparam int SIZE   = 32;
  localparam int MAX    = 13;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  instruction_loader_if #(.SIZE(SIZE), .MAX_INSTRUCTION(MAX)) bus ();

  instruction_loader #(.SIZE(SIZE), .MAX_INSTRUCTION(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a load is a queue of received bytes; every four bytes
  // form a word, and the write address is simply the number of words so far.
  typedef enum {M_IDLE, M_RECV, M_DONE} mstate_t;
  mstate_t           m_state = M_IDLE;
  logic [7:0]        m_bytes[$];
  int                m_count = 0;
  logic              m_full  = 1'b0;
  logic              m_wr_en = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [31:0]       m_data  = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;
  wr_t wlog[$];

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        loading;
    logic        done;
    logic        full;
    logic [4:0]  count;
  } vec_t;
  vec_t vecs[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelStep(input logic s, input logic v, input logic [7:0] d, input logic r);
    logic [31:0] w;
    if (r) begin
      m_state = M_IDLE;
      m_bytes.delete();
      m_count = 0;
      m_full  = 1'b0;
      m_wr_en = 1'b0;
      m_addr  = '0;
      m_data  = '0;
    end else begin
      m_wr_en = 1'b0;
      case (m_state)
        M_IDLE, M_DONE: begin
          if (s) begin
            m_state = M_RECV;
            m_bytes.delete();
            m_count = 0;
            m_full  = 1'b0;
          end
        end
        M_RECV: begin
          if (v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
              w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
              m_bytes.delete();
              if (w == 32'hFFFF_FFFF) begin
                m_state = M_DONE;
              end else begin
                m_wr_en = 1'b1;
                m_addr  = ADDR_W'(m_count);
                m_data  = w;
                m_count = m_count + 1;
                if (m_count == MAX) begin
                  m_state = M_DONE;
                  m_full  = 1'b1;
                end
              end
            end
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  // One clock cycle: drive inputs, let the DUT sample them, advance the model,
  // then settle 1 time unit past the edge and log any write strobe.
  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d, input logic r);
    rst            = r;
    bus.i_start    = s;
    bus.i_rx_valid = v;
    bus.i_rx_data  = d;
    @(posedge clk);
    cyc++;
    modelStep(s, v, d, r);
    #1;
    if (bus.o_wr_en === 1'b1) begin
      wlog.push_back('{bus.o_wr_addr, bus.o_wr_data, cyc});
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " wr_en"},      32'(bus.o_wr_en),      32'(m_wr_en));
    checkVal({tag, " wr_addr"},    32'(bus.o_wr_addr),    32'(m_addr));
    checkVal({tag, " wr_data"},    bus.o_wr_data,         m_data);
    checkVal({tag, " loading"},    32'(bus.o_loading),    32'(m_state == M_RECV));
    checkVal({tag, " done"},       32'(bus.o_done),       32'(m_state == M_DONE));
    checkVal({tag, " full"},       32'(bus.o_full),       32'(m_full));
    checkVal({tag, " word_count"}, 32'(bus.o_word_count), 32'(m_count));
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic r, input string tag);
    applyStimulus(s, v, d, r);
    checkOutput(tag);
  endtask

  task automatic sendByte(input logic [7:0] d, input string tag);
    step(1'b0, 1'b1, d, 1'b0, tag);
  endtask

  task automatic addVec(input logic s, input logic v, input logic [7:0] d, input logic r,
                        input logic we, input logic [3:0] a, input logic [31:0] dat,
                        input logic ld, input logic dn, input logic fl, input logic [4:0] cnt);
    vec_t t;
    t.s = s; t.v = v; t.d = d; t.r = r;
    t.we = we; t.addr = a; t.data = dat;
    t.loading = ld; t.done = dn; t.full = fl; t.count = cnt;
    vecs.push_back(t);
  endtask

  task automatic checkTable(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    checkVal({tag, " wr_en"},      32'(bus.o_wr_en),      32'(vecs[i].we));
    checkVal({tag, " wr_addr"},    32'(bus.o_wr_addr),    32'(vecs[i].addr));
    checkVal({tag, " wr_data"},    bus.o_wr_data,         vecs[i].data);
    checkVal({tag, " loading"},    32'(bus.o_loading),    32'(vecs[i].loading));
    checkVal({tag, " done"},       32'(bus.o_done),       32'(vecs[i].done));
    checkVal({tag, " full"},       32'(bus.o_full),       32'(vecs[i].full));
    checkVal({tag, " word_count"}, 32'(bus.o_word_count), 32'(vecs[i].count));
  endtask

  initial begin
    logic [7:0] pend[$];
    logic       rs, rr, rv;
    logic [7:0] rd;

    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;

    // ---- Table: normal load, then restart from DONE ----
    //      s  v  d      r  | we a  data           ld dn fl cnt
    addVec(0, 0, 8'h00, 1,   0, 0, 32'h0,          0, 0, 0, 0);
    addVec(1, 0, 8'h00, 0,   0, 0, 32'h0,          1, 0, 0, 0);
    addVec(0, 1, 8'h3C, 0,   0, 0, 32'h0,          1, 0, 0, 0);
    addVec(0, 1, 8'h01, 0,   0, 0, 32'h0,          1, 0, 0, 0);
    addVec(0, 1, 8'h01, 0,   0, 0, 32'h0,          1, 0, 0, 0);
    addVec(0, 1, 8'h01, 0,   1, 0, 32'h3C01_0101,  1, 0, 0, 1);
    addVec(0, 1, 8'h3C, 0,   0, 0, 32'h3C01_0101,  1, 0, 0, 1);
    addVec(0, 1, 8'h03, 0,   0, 0, 32'h3C01_0101,  1, 0, 0, 1);
    addVec(0, 1, 8'h00, 0,   0, 0, 32'h3C01_0101,  1, 0, 0, 1);
    addVec(0, 1, 8'h03, 0,   1, 1, 32'h3C03_0003,  1, 0, 0, 2);
    addVec(0, 1, 8'hFF, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 2);
    addVec(0, 1, 8'hFF, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 2);
    addVec(0, 1, 8'hFF, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 2);
    addVec(0, 1, 8'hFF, 0,   0, 1, 32'h3C03_0003,  0, 1, 0, 2);
    addVec(0, 0, 8'h00, 0,   0, 1, 32'h3C03_0003,  0, 1, 0, 2);
    addVec(1, 0, 8'h00, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 0);
    addVec(0, 1, 8'h00, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 0);
    addVec(0, 1, 8'h00, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 0);
    addVec(0, 1, 8'h00, 0,   0, 1, 32'h3C03_0003,  1, 0, 0, 0);
    addVec(0, 1, 8'h2A, 0,   1, 0, 32'h0000_002A,  1, 0, 0, 1);
    addVec(0, 1, 8'hFF, 0,   0, 0, 32'h0000_002A,  1, 0, 0, 1);
    addVec(0, 1, 8'hFF, 0,   0, 0, 32'h0000_002A,  1, 0, 0, 1);
    addVec(0, 1, 8'hFF, 0,   0, 0, 32'h0000_002A,  1, 0, 0, 1);
    addVec(0, 1, 8'hFF, 0,   0, 0, 32'h0000_002A,  0, 1, 0, 1);

    $display("[TB] table vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].r);
      checkTable(i);
    end

    // ---- Overflow: 13 words with no marker fill the memory ----
    step(0, 0, 8'h00, 1, "ovf rst");
    wlog.delete();
    step(1, 0, 8'h00, 0, "ovf start");
    for (int w = 1; w <= MAX; w++) begin
      sendByte(8'h00, "ovf b0");
      sendByte(8'h00, "ovf b1");
      sendByte(8'h00, "ovf b2");
      sendByte(8'(w), "ovf b3");
    end
    checkVal("ovf last wr_en", 32'(bus.o_wr_en), 32'd1);
    checkVal("ovf last done", 32'(bus.o_done), 32'd1);
    checkVal("ovf last full", 32'(bus.o_full), 32'd1);
    checkVal("ovf word_count", 32'(bus.o_word_count), 32'd13);
    for (int k = 0; k < 4; k++) sendByte(8'h55, "ovf extra");
    checkVal("ovf write total", 32'(wlog.size()), 32'd13);
    for (int k = 0; k < wlog.size(); k++) begin
      checkVal($sformatf("ovf addr%0d", k), 32'(wlog[k].addr), 32'(k));
      checkVal($sformatf("ovf data%0d", k), wlog[k].data, 32'(k + 1));
    end

    // ---- Reset in the middle of a word ----
    step(1, 0, 8'h00, 0, "rstmid start");
    wlog.delete();
    sendByte(8'hAA, "rstmid AA");
    sendByte(8'hBB, "rstmid BB");
    step(0, 0, 8'h00, 1, "rstmid rst");
    checkVal("rstmid loading after rst", 32'(bus.o_loading), 32'd0);
    step(1, 0, 8'h00, 0, "rstmid restart");
    sendByte(8'h11, "rstmid 11");
    sendByte(8'h22, "rstmid 22");
    sendByte(8'h33, "rstmid 33");
    sendByte(8'h44, "rstmid 44");
    checkVal("rstmid write total", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      checkVal("rstmid addr", 32'(wlog[0].addr), 32'd0);
      checkVal("rstmid data", wlog[0].data, 32'h1122_3344);
    end

    // ---- Ignored inputs: bytes in IDLE, start during RECV ----
    step(0, 0, 8'h00, 1, "ign rst");
    wlog.delete();
    sendByte(8'hDE, "ign DE");
    sendByte(8'hAD, "ign AD");
    sendByte(8'hBE, "ign BE");
    step(1, 1, 8'hEF, 0, "ign start+EF");
    checkVal("ign idle writes", 32'(wlog.size()), 32'd0);
    sendByte(8'h01, "ign 01");
    sendByte(8'h02, "ign 02");
    step(1, 0, 8'h00, 0, "ign start in recv");
    sendByte(8'h03, "ign 03");
    sendByte(8'h04, "ign 04");
    checkVal("ign write total", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      checkVal("ign addr", 32'(wlog[0].addr), 32'd0);
      checkVal("ign data", wlog[0].data, 32'h0102_0304);
    end

    // ---- Throughput: 12 back-to-back bytes ----
    step(0, 0, 8'h00, 1, "thr rst");
    step(1, 0, 8'h00, 0, "thr start");
    wlog.delete();
    for (int k = 0; k < 12; k++) sendByte(8'(8'h10 + k), "thr byte");
    step(0, 0, 8'h00, 0, "thr idle");
    checkVal("thr write total", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      checkVal("thr data0", wlog[0].data, 32'h1011_1213);
      checkVal("thr data1", wlog[1].data, 32'h1415_1617);
      checkVal("thr data2", wlog[2].data, 32'h1819_1A1B);
      for (int k = 0; k < 3; k++) begin
        checkVal($sformatf("thr addr%0d", k), 32'(wlog[k].addr), 32'(k));
      end
      checkVal("thr spacing01", 32'(wlog[1].cyc - wlog[0].cyc), 32'd4);
      checkVal("thr spacing12", 32'(wlog[2].cyc - wlog[1].cyc), 32'd4);
    end

    // ---- Randomized run against the reference model ----
    step(0, 0, 8'h00, 1, "rand rst");
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 2) != 0);
      rd = 8'($urandom);
      if (rr || (rs && m_state != M_RECV)) pend.delete();
      if (rv && m_state == M_RECV && !rr) begin
        if (pend.size() == 0) begin
          if ($urandom_range(0, 4) == 0) begin
            for (int k = 0; k < 4; k++) pend.push_back(8'hFF);
          end else begin
            for (int k = 0; k < 4; k++) pend.push_back(8'($urandom));
          end
        end
        rd = pend.pop_front();
      end
      step(rs, rv, rd, rr, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
